// File: rtl/pulse_sequencer.sv
// Step-table scheduler for a bank of NCH one-shot pulse channels: for each step it
// loads the length, triggers the channel, waits for the pulse to finish, then idles for the gap.
module pulse_sequencer #(
  parameter  int NCH     = 4,
  parameter  int DEPTH   = 16,
  parameter  int TIMEOUT = 255,
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int EW      = 16 + CHW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_we_i,
  input  logic [AW-1:0]  cfg_addr_i,
  input  logic [EW-1:0]  cfg_wdata_i,
  input  logic [AW:0]    num_steps_i,
  input  logic           loop_en_i,
  input  logic           start_i,
  input  logic           abort_i,
  input  logic [NCH-1:0] ch_out_i,
  output logic [7:0]     ch_data_o,
  output logic [NCH-1:0] ch_load_o,
  output logic [NCH-1:0] ch_trigger_o,
  output logic           busy_o,
  output logic [AW-1:0]  cur_step_o,
  output logic           done_o,
  output logic           err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ARM, S_WAIT_HI, S_WAIT_LO, S_GAP, S_NEXT
  } state_e;

  localparam logic [CHW:0] NCH_L  = (CHW+1)'(NCH);
  localparam logic [15:0]  TMR_HI = 16'(TIMEOUT - 1);

  state_e         state_q, state_d;
  logic [AW:0]    step_q, step_d, num_q, num_d;
  logic [CHW-1:0] cur_ch_q, cur_ch_d;
  logic [7:0]     len_q, len_d, gap_q, gap_d, gcnt_q, gcnt_d;
  logic [15:0]    tmr_q, tmr_d;
  logic           err_q, err_d;

  logic [EW-1:0]  tbl_q [DEPTH];
  logic [EW-1:0]  ent;
  logic [CHW-1:0] ent_ch;
  logic [7:0]     ent_len, ent_gap;
  logic           ent_ok, pulse_hi, last_step;

  function automatic logic [NCH-1:0] onehot(input logic [CHW-1:0] c);
    onehot = NCH'(1) << c;
  endfunction

  // Table has no reset: contents are only meaningful once the host writes them.
  always_ff @(posedge clk)
    if (cfg_we_i) tbl_q[cfg_addr_i] <= cfg_wdata_i;

  assign ent       = tbl_q[step_q[AW-1:0]];
  assign ent_ch    = ent[CHW-1:0];
  assign ent_len   = ent[CHW+7:CHW];
  assign ent_gap   = ent[CHW+15:CHW+8];
  assign ent_ok    = {1'b0, ent_ch} < NCH_L;
  assign pulse_hi  = |(ch_out_i & onehot(cur_ch_q));
  assign last_step = (step_q == num_q - (AW+1)'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      step_q   <= '0;
      num_q    <= '0;
      cur_ch_q <= '0;
      len_q    <= '0;
      gap_q    <= '0;
      gcnt_q   <= '0;
      tmr_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      num_q    <= num_d;
      cur_ch_q <= cur_ch_d;
      len_q    <= len_d;
      gap_q    <= gap_d;
      gcnt_q   <= gcnt_d;
      tmr_q    <= tmr_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    num_d    = num_q;
    cur_ch_d = cur_ch_q;
    len_d    = len_q;
    gap_d    = gap_q;
    gcnt_d   = gcnt_q;
    tmr_d    = tmr_q;
    err_d    = err_q;
    // abort also covers IDLE, so a simultaneous start is dropped
    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:
          if (start_i && num_steps_i != '0) begin
            num_d   = num_steps_i;
            step_d  = '0;
            err_d   = 1'b0;
            state_d = S_LOAD;
          end
        S_LOAD: begin
          cur_ch_d = ent_ch;
          gap_d    = ent_gap;
          if (ent_ok) begin
            len_d   = ent_len;
            state_d = S_ARM;
          end else begin
            err_d   = 1'b1;
            state_d = S_NEXT;
          end
        end
        S_ARM: begin
          tmr_d   = 16'd1;  // trigger cycle counts toward the timeout
          state_d = S_WAIT_HI;
        end
        S_WAIT_HI:
          if (pulse_hi) begin
            state_d = S_WAIT_LO;
          end else if (tmr_q >= TMR_HI) begin
            err_d   = 1'b1;
            state_d = S_NEXT;
          end else begin
            tmr_d = tmr_q + 16'd1;
          end
        S_WAIT_LO:
          if (!pulse_hi) begin
            if (gap_q == 8'd0) begin
              state_d = S_NEXT;
            end else begin
              gcnt_d  = 8'd1;
              state_d = S_GAP;
            end
          end
        S_GAP:
          if (gcnt_q >= gap_q) state_d = S_NEXT;
          else                 gcnt_d  = gcnt_q + 8'd1;
        S_NEXT:
          if (!last_step) begin
            step_d  = step_q + (AW+1)'(1);
            state_d = S_LOAD;
          end else if (loop_en_i) begin
            step_d  = '0;
            state_d = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o       = (state_q != S_IDLE);
    cur_step_o   = step_q[AW-1:0];
    err_o        = err_q;
    ch_data_o    = len_q;
    ch_load_o    = '0;
    ch_trigger_o = '0;
    done_o       = 1'b0;
    if (!abort_i) begin
      case (state_q)
        S_LOAD:
          if (ent_ok) begin
            ch_data_o = ent_len;
            ch_load_o = onehot(ent_ch);
          end
        S_ARM:   ch_trigger_o = onehot(cur_ch_q);
        S_NEXT:  done_o       = last_step && !loop_en_i;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed bench for pulse_sequencer with a behavioural channel bank that echoes
// ch_out for len+1 cycles after each trigger. NCH=5 so that ch=7 is encodable.
module tb_pulse_sequencer;
  localparam int NCH = 5, DEPTH = 16, TIMEOUT = 255;
  localparam int CHW = 3, AW = 4, EW = 19;

  logic           clk = 1'b0, rst = 1'b1;
  logic           cfg_we, loop_en, start, abort;
  logic [AW-1:0]  cfg_addr;
  logic [EW-1:0]  cfg_wdata;
  logic [AW:0]    num_steps;
  logic [NCH-1:0] ch_out, mute;
  logic [7:0]     ch_data;
  logic [NCH-1:0] ch_load, ch_trigger;
  logic           busy, done, err;
  logic [AW-1:0]  cur_step;

  int n_chk = 0, n_fail = 0, done_cnt = 0;
  logic [NCH-1:0] tlog_ch [$];
  logic [AW-1:0]  tlog_step [$];
  logic [7:0]     mlen [NCH] = '{default: 8'd0};
  int unsigned    mcnt [NCH] = '{default: 0};

  always #5 clk = ~clk;

  pulse_sequencer #(.NCH(NCH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
    .num_steps_i(num_steps), .loop_en_i(loop_en), .start_i(start), .abort_i(abort),
    .ch_out_i(ch_out), .ch_data_o(ch_data), .ch_load_o(ch_load), .ch_trigger_o(ch_trigger),
    .busy_o(busy), .cur_step_o(cur_step), .done_o(done), .err_o(err)
  );

  // Channel bank model; mute forces a channel's output low.
  always @(posedge clk)
    for (int i = 0; i < NCH; i++) begin
      if (ch_load[i]) mlen[i] <= ch_data;
      if (ch_trigger[i])     mcnt[i] <= int'(mlen[i]) + 1;
      else if (mcnt[i] != 0) mcnt[i] <= mcnt[i] - 1;
    end

  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign ch_out[g] = (mcnt[g] != 0) && !mute[g];
  end

  always @(negedge clk)
    if (!rst) begin
      if (|ch_trigger) begin
        tlog_ch.push_back(ch_trigger);
        tlog_step.push_back(cur_step);
      end
      if (done) done_cnt++;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int addr, input int ch, input int len, input int gap);
    cfg_we    = 1'b1;
    cfg_addr  = AW'(addr);
    cfg_wdata = {8'(gap), 8'(len), 3'(ch)};
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  task automatic clr_logs();
    tlog_ch.delete();
    tlog_step.delete();
    done_cnt = 0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while (busy && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; num_steps = 0; loop_en = 0;
    start = 0; abort = 0; mute = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_load", ch_load, 0);
    chk("rst_trig", ch_trigger, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_step", cur_step, 0);
    chk("rst_data", ch_data, 0);
    rst = 1'b0;
    @(negedge clk);

    // single step ch1 len5 gap3: pulse high C3..C8, gap C10..C12, done in C13
    wr(0, 1, 5, 3);
    num_steps = 1; loop_en = 0; start = 1;
    @(negedge clk); start = 0;
    chk("t1_load", ch_load, 5'b00010);
    chk("t1_data", ch_data, 8'd5);
    chk("t1_busy", busy, 1);
    @(negedge clk);
    chk("t1_trig", ch_trigger, 5'b00010);
    chk("t1_load_off", ch_load, 0);
    chk("t1_data_hold", ch_data, 8'd5);
    repeat (10) @(negedge clk);
    chk("t1_no_early_done", done, 0);
    @(negedge clk);
    chk("t1_done", done, 1);
    @(negedge clk);
    chk("t1_done_1cyc", done, 0);
    chk("t1_idle", busy, 0);

    // three steps, ch0/ch2/ch3
    wr(0, 0, 2, 0); wr(1, 2, 1, 1); wr(2, 3, 0, 0);
    clr_logs();
    num_steps = 3; start = 1;
    @(negedge clk); start = 0;
    wait_idle("t2_idle", 100);
    chk("t2_ntrig", tlog_ch.size(), 3);
    if (tlog_ch.size() == 3) begin
      chk("t2_trig0", tlog_ch[0], 5'b00001);
      chk("t2_trig1", tlog_ch[1], 5'b00100);
      chk("t2_trig2", tlog_ch[2], 5'b01000);
      chk("t2_step0", tlog_step[0], 0);
      chk("t2_step1", tlog_step[1], 1);
      chk("t2_step2", tlog_step[2], 2);
    end
    chk("t2_ndone", done_cnt, 1);
    chk("t2_err", err, 0);

    // ch2 never pulses: err rises exactly 255 cycles after the trigger
    wr(0, 2, 3, 0); wr(1, 0, 1, 0);
    clr_logs();
    mute = 5'b00100; num_steps = 2; start = 1;
    @(negedge clk); start = 0;
    @(negedge clk);
    chk("t3_trig", ch_trigger, 5'b00100);
    repeat (254) @(negedge clk);
    chk("t3_err_early", err, 0);
    chk("t3_busy", busy, 1);
    @(negedge clk);
    chk("t3_err", err, 1);
    chk("t3_step_still0", cur_step, 0);
    @(negedge clk);
    chk("t3_next_load", ch_load, 5'b00001);
    chk("t3_next_step", cur_step, 1);
    mute = 0;
    wait_idle("t3_idle", 50);
    chk("t3_err_sticky", err, 1);
    chk("t3_ndone", done_cnt, 1);
    chk("t3_ntrig", tlog_ch.size(), 2);

    // bad channel index skips its strobes; start clears previous err
    wr(0, 7, 4, 2); wr(1, 3, 1, 0);
    clr_logs();
    num_steps = 2; start = 1;
    @(negedge clk); start = 0;
    chk("t4_err_cleared", err, 0);
    chk("t4_no_load", ch_load, 0);
    @(negedge clk);
    chk("t4_err", err, 1);
    chk("t4_no_trig", ch_trigger, 0);
    @(negedge clk);
    chk("t4_load1", ch_load, 5'b01000);
    chk("t4_step1", cur_step, 1);
    wait_idle("t4_idle", 50);
    chk("t4_ntrig", tlog_ch.size(), 1);
    chk("t4_ndone", done_cnt, 1);
    chk("t4_err_kept", err, 1);

    // looping run, abort in WAIT_LO of step 1 (pulse high C9..C29)
    wr(0, 0, 1, 0); wr(1, 1, 20, 0);
    clr_logs();
    num_steps = 2; loop_en = 1; start = 1;
    @(negedge clk); start = 0;
    repeat (6) @(negedge clk);
    chk("t5_load1", ch_load, 5'b00010);
    chk("t5_step1", cur_step, 1);
    repeat (5) @(negedge clk);
    chk("t5_busy_pre", busy, 1);
    abort = 1;
    @(negedge clk);
    chk("t5_abort_idle", busy, 0);
    chk("t5_abort_load", ch_load, 0);
    chk("t5_abort_trig", ch_trigger, 0);
    start = 1;
    @(negedge clk);
    chk("t5_abort_beats_start", busy, 0);
    abort = 0;
    @(negedge clk); start = 0;
    chk("t5_restart_load", ch_load, 5'b00001);
    chk("t5_restart_step", cur_step, 0);
    repeat (30) @(negedge clk);
    chk("t5_loop_no_done", done, 0);
    chk("t5_loop_busy", busy, 1);
    chk("t5_loop_last", cur_step, 1);
    @(negedge clk);
    chk("t5_wrap_load", ch_load, 5'b00001);
    chk("t5_wrap_step", cur_step, 0);
    abort = 1;
    @(negedge clk);
    chk("t5_abort2_idle", busy, 0);
    abort = 0; loop_en = 0;
    chk("t5_ndone", done_cnt, 0);

    // reset in the middle of a 10-cycle gap
    wr(0, 4, 1, 10);
    num_steps = 1; start = 1;
    @(negedge clk); start = 0;
    repeat (7) @(negedge clk);
    chk("t6_in_gap", busy, 1);
    chk("t6_data", ch_data, 8'd1);
    rst = 1;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_data", ch_data, 0);
    chk("t6_rst_step", cur_step, 0);
    chk("t6_rst_load", ch_load, 0);
    chk("t6_rst_trig", ch_trigger, 0);
    chk("t6_rst_done", done, 0);
    @(negedge clk);
    rst = 0; num_steps = 0; start = 1;
    repeat (3) @(negedge clk);
    chk("t6_zero_steps", busy, 0);
    start = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
